serial_compare_sequencer: RTL
=============================

// Module: serial_compare_sequencer
//
// PURPOSE
//  Accepts a pair of WIDTH-bit operands over a valid/ready handshake.
//  Feeds them one bit per clock, MSB first, into an embedded three-state serial comparator FSM.
//  Returns a one-hot less/equal/greater result over a second valid/ready handshake.
//  Sits between a parallel producer and a consumer that wants a magnitude compare
//  without a WIDTH-bit combinational comparator.
//
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range 1..64
//
// PORTS
//  clk           in   1      clock; all state changes on posedge clk
//  rst           in   1      synchronous, active-high reset
//  up_valid      in   1      operand pair valid
//  up_ready      out  1      sequencer can accept an operand pair
//  up_a          in   WIDTH  operand A
//  up_b          in   WIDTH  operand B
//  down_valid    out  1      result valid
//  down_ready    in   1      consumer accepts result
//  down_less     out  1      A < B
//  down_eq       out  1      A == B
//  down_greater  out  1      A > B
//  busy          out  1      high in SHIFT or DONE
//
// BEHAVIOUR
//  - Reset: state=IDLE, up_ready=1, down_valid=0, results=0, busy=0.
//    Shift registers, counter and compare state are cleared.
//  - Controller states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: up_ready=1.
//    - On up_valid & up_ready: load up_a/up_b into shift regs,
//      set cnt=WIDTH-1, set cmp=EQ, go to SHIFT.
//  - SHIFT: up_ready=0. Each cycle:
//    - Take bits a=sa[WIDTH-1], b=sb[WIDTH-1]; shift both left by 1; cnt--.
//    - cmp update, MSB-first:
//      - EQ: a<b -> LESS; a>b -> GREATER; otherwise stay EQ.
//      - LESS and GREATER are sticky.
//    - When cnt==0, the current bit is the last: register the final cmp into the
//      result regs and go to DONE.
//  - DONE:
//    - down_valid=1; the result is one-hot and stable while down_valid=1 and down_ready=0.
//    - On down_ready: go to IDLE next cycle.
//    - up_ready rises the cycle after the down handshake; no same-cycle bypass.
//  - Latency (no early exit): accept at cycle T -> down_valid at T+WIDTH+1.
//  - Throughput: one compare per WIDTH+2 cycles, given down_ready=1 and up_valid=1.
//  - Results are forced to 0 whenever down_valid=0.
//  - up_a/up_b are ignored outside the accept cycle.
//    Operand changes during SHIFT do not affect the result.
//  - up_valid held high in SHIFT/DONE: no accept; the pair waits for IDLE.
//  - WIDTH=1: exactly one SHIFT cycle.
//  - rst mid-SHIFT or in DONE: abort with no result emitted; return to the reset state next cycle.
//  - The encoding of the illegal cmp value decodes to EQ. The illegal controller state decodes to IDLE.
//
// CONFIGURATION
//  SERIAL_CMP_EARLY_EXIT_EN
//  - Defined: in SHIFT, as soon as the updated cmp is LESS or GREATER, register the
//    result and go to DONE, even if cnt!=0.
//    - Latency is k+1 cycles, where k is the index, counted from the MSB, of the first
//      differing bit (MSB difference -> down_valid at T+2).
//    - Equal operands still take WIDTH+1 cycles.
//  - Undefined: always shift all WIDTH bits; latency is fixed at WIDTH+1.
//
// TESTING (WIDTH=8)
//  - Reset check: rst held 3 cycles -> up_ready=1, down_valid=0, all results 0.
//  - a=0x5A, b=0x5A, down_ready=1 -> eq=1 at T+9; up_ready=1 at T+10.
//  - a=0x80, b=0x7F -> greater=1; at T+9 without the macro, at T+2 with it.
//  - a=0x3C, b=0x3D -> less=1 at T+9 in both builds; first difference is the LSB.
//  - down_ready=0 for 5 cycles in DONE -> down_valid and less held stable;
//    up_ready=0 throughout; the up_a change is ignored.
//  - Back-to-back pairs with rst asserted at SHIFT cycle 4 of the 2nd pair
//    -> only the 1st result is emitted; after rst the 3rd pair completes normally.

Source files
------------

// File: rtl/serial_compare_sequencer.sv
// Bit-serial magnitude comparator: accepts an operand pair, compares MSB first
// over WIDTH cycles and returns a one-hot less/eq/greater result.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN finishes on the first differing bit.
module serial_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_less,
  output logic             down_eq,
  output logic             down_greater,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CMP_EQ      = 2'b00,
    CMP_LESS    = 2'b01,
    CMP_GREATER = 2'b10
  } cmp_e;

  state_e           state_q;
  cmp_e             cmp_q;
  cmp_e             cmp_cur;
  cmp_e             cmp_d;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             up_ready_q;
  logic             down_valid_q;
  logic             less_q;
  logic             eq_q;
  logic             greater_q;
  logic             busy_q;
  logic             bit_a;
  logic             bit_b;
  logic             last_bit;

  assign bit_a = sa_q[WIDTH-1];
  assign bit_b = sb_q[WIDTH-1];

  // The unused cmp encoding collapses to EQ so a corrupted value cannot stick.
  always_comb begin
    cmp_cur = CMP_EQ;
    case (cmp_q)
      CMP_LESS:    cmp_cur = CMP_LESS;
      CMP_GREATER: cmp_cur = CMP_GREATER;
      default:     cmp_cur = CMP_EQ;
    endcase
    cmp_d = cmp_cur;
    if (cmp_cur == CMP_EQ) begin
      if (!bit_a && bit_b) begin
        cmp_d = CMP_LESS;
      end else if (bit_a && !bit_b) begin
        cmp_d = CMP_GREATER;
      end
    end
  end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last_bit = (cnt_q == '0) || (cmp_d != CMP_EQ);
`else
  assign last_bit = (cnt_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmp_q        <= CMP_EQ;
      sa_q         <= '0;
      sb_q         <= '0;
      cnt_q        <= '0;
      up_ready_q   <= 1'b1;
      down_valid_q <= 1'b0;
      less_q       <= 1'b0;
      eq_q         <= 1'b0;
      greater_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          sa_q  <= sa_q << 1;
          sb_q  <= sb_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
          cmp_q <= cmp_d;
          if (last_bit) begin
            state_q      <= ST_DONE;
            down_valid_q <= 1'b1;
            less_q       <= (cmp_d == CMP_LESS);
            eq_q         <= (cmp_d == CMP_EQ);
            greater_q    <= (cmp_d == CMP_GREATER);
          end
        end
        ST_DONE: begin
          if (down_ready) begin
            state_q      <= ST_IDLE;
            down_valid_q <= 1'b0;
            less_q       <= 1'b0;
            eq_q         <= 1'b0;
            greater_q    <= 1'b0;
            up_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          // IDLE, and the recovery path for the unused state encoding.
          state_q      <= ST_IDLE;
          up_ready_q   <= 1'b1;
          down_valid_q <= 1'b0;
          less_q       <= 1'b0;
          eq_q         <= 1'b0;
          greater_q    <= 1'b0;
          busy_q       <= 1'b0;
          if (up_valid && up_ready_q) begin
            state_q    <= ST_SHIFT;
            sa_q       <= up_a;
            sb_q       <= up_b;
            cnt_q      <= CNT_W'(WIDTH - 1);
            cmp_q      <= CMP_EQ;
            up_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign up_ready     = up_ready_q;
  assign down_valid   = down_valid_q;
  assign down_less    = less_q;
  assign down_eq      = eq_q;
  assign down_greater = greater_q;
  assign busy         = busy_q;

endmodule
